// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } lsu_state_t;

  // Reserved size 2'b11 is checked like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte/half lane extract with extension, and store merge
// Ports:
//   word       in   read word from memory
//   off        in   byte offset within the word (addr[1:0])
//   size       in   access size
//   zext       in   zero-extend sub-word loads when 1
//   wdata      in   right-aligned store data
//   load_val   out  extracted, extended load value
//   store_word out  read word with the selected lane(s) replaced by wdata
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  lsu_size_t   size,
  input  logic        zext,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v     = word[{off, 3'b000} +: 8];
    // Halves only use off[1]; a set off[0] is masked away.
    half_v     = off[1] ? word[31:16] : word[15:0];
    load_val   = word;
    store_word = wdata;
    case (size)
      SZ_BYTE: begin
        load_val   = zext ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
        store_word = word;
        store_word[{off, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_val   = zext ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
        store_word = word;
        if (off[1]) store_word[31:16] = wdata[15:0];
        else        store_word[15:0]  = wdata[15:0];
      end
      default: begin
        load_val   = word;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_dmem_master.sv
// rtl/lsu_dmem_master.sv - load/store unit, initiator side of the data-memory port
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned / reserved-size requests
// complete with resp_err=1 and no memory access).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             core request handshake
//   req_we/req_size/req_unsigned    store flag, access size, zero-extend loads
//   req_addr/req_wdata              byte address, right-aligned store data
//   resp_valid/resp_rdata/resp_err  one-cycle completion, load data, error
//   mem_addr/mem_write              word index and write strobe to dmem
//   mem_write_data                  full word to write
//   mem_data/mem_valid              read word and completion from dmem
module lsu_dmem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_data,
  input  logic              mem_valid
);

  lsu_state_t        state, state_nxt;
  logic              we_q;
  lsu_size_t         size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rword_q;
  logic [31:0]       mem_wdata_q;

  logic              accept;
  logic              req_is_word;
  logic              trap;
  logic              err_flag;
  logic [31:0]       align_word;
  logic [31:0]       load_val;
  logic [31:0]       store_word;

  assign accept      = req_valid && (state == IDLE);
  // Reserved size behaves as a word access.
  assign req_is_word = req_size[1];

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  assign trap     = is_misaligned(req_size, req_addr[1:0]) || (req_size == 2'b11);
  assign err_flag = err_q;

  always_ff @(posedge clk) begin
    if (reset)       err_q <= 1'b0;
    else if (accept) err_q <= trap;
  end
`else
  assign trap     = 1'b0;
  assign err_flag = 1'b0;
`endif

  // The merge needs the word as it arrives in RD; the load path uses the latched copy.
  assign align_word = (state == RD) ? mem_data : rword_q;

  lsu_lane_align u_align (
    .word       (align_word),
    .off        (addr_q[1:0]),
    .size       (size_q),
    .zext       (uns_q),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (trap)                      state_nxt = RESP;
          else if (req_we && req_is_word) state_nxt = WR;
          else                           state_nxt = RD;
        end
      end
      RD:      if (mem_valid) state_nxt = we_q ? WR : RESP;
      WR:      if (mem_valid) state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // Request and data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rword_q     <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_is_word ? SZ_WORD : lsu_size_t'(req_size);
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        // Word stores skip RD, so their write word is known at accept.
        if (req_we && req_is_word) mem_wdata_q <= req_wdata;
      end
      if (state == RD && mem_valid) begin
        rword_q     <= mem_data;
        mem_wdata_q <= store_word;
      end
    end
  end

  // Outputs: decoded from registered state only, so mem_write cannot glitch.
  always_comb begin
    req_ready      = (state == IDLE);
    resp_valid     = (state == RESP);
    mem_write      = (state == WR);
    resp_err       = (state == RESP) && err_flag;
    resp_rdata     = '0;
    if (state == RESP && !we_q && !err_flag) resp_rdata = load_val;
    mem_addr       = {2'b00, addr_q[ADDR_W-1:2]};
    mem_write_data = mem_wdata_q;
  end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb/tb_lsu_dmem_master.sv - scoreboard bench for lsu_dmem_master
module tb_lsu_dmem_master;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_data;
  logic        mem_valid = 1'b1;

  logic [31:0] mem [16];
  logic [31:0] last_waddr;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          mw;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_dmem_master #(.ADDR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write      (mem_write),
    .mem_write_data (mem_write_data),
    .mem_data       (mem_data),
    .mem_valid      (mem_valid)
  );

  // Memory model: combinational read, write on the clock while strobe and valid are high.
  assign mem_data = mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h8899AABB;
      mem[2] <= 32'h11223344;
    end else if (mem_write && mem_valid) begin
      mem[mem_addr[3:0]] <= mem_write_data;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_mw, input int stall);
    exp_t e;
    exp_t got;
    int   n;
    int   mw;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    mem_valid    = (stall == 0);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_val({tag, "_ready_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    e.rd = exp_rd; e.err = exp_err; e.lat = exp_lat; e.mw = exp_mw;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    n  = 1;
    mw = 0;
    while (!resp_valid && n < 50) begin
      if (mem_write) begin
        mw++;
        last_waddr = mem_addr;
      end
      if (stall > 0) check_val({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
      if (n > stall) mem_valid = 1'b1;
      @(negedge clk);
      n++;
    end
    got = sb.pop_front();
    if (!resp_valid) begin
      check_val({tag, "_resp_timeout"}, 32'd0, 32'd1);
    end else begin
      check_val({tag, "_rdata"}, resp_rdata, got.rd);
      check_val({tag, "_err"}, 32'(resp_err), 32'(got.err));
      check_val({tag, "_lat"}, 32'(n), 32'(got.lat));
      check_val({tag, "_mwrite_cycles"}, 32'(mw), 32'(got.mw));
      // A request presented during RESP must not be taken at that edge.
      req_valid = 1'b1;
      req_we    = 1'b0;
      check_val({tag, "_ready_in_resp"}, 32'(req_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check_val({tag, "_idle_after_resp"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
    end
    mem_valid = 1'b1;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_val("rst_ready", 32'(req_ready), 32'd1);
    check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_val("rst_rdata", resp_rdata, 32'd0);
    check_val("rst_err", 32'(resp_err), 32'd0);
    check_val("rst_mem_write", 32'(mem_write), 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    check_val("rst_mem_wdata", mem_write_data, 32'd0);

    do_req("lb6",  1'b0, 2'b00, 1'b0, 32'h6, 32'h0, 32'hFFFFFF99, 1'b0, 2, 0, 0);
    do_req("lbu6", 1'b0, 2'b00, 1'b1, 32'h6, 32'h0, 32'h00000099, 1'b0, 2, 0, 0);
    do_req("lb4",  1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 0, 0);
    do_req("lb7",  1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 32'hFFFFFF88, 1'b0, 2, 0, 0);

    do_req("sb9", 1'b1, 2'b00, 1'b0, 32'h9, 32'h000000EE, 32'h0, 1'b0, 3, 1, 0);
    check_val("sb9_mem", mem[2], 32'h1122EE44);

    do_req("sh2", 1'b1, 2'b01, 1'b0, 32'h2, 32'h0000BEEF, 32'h0, 1'b0, 3, 1, 0);
    check_val("sh2_mem", mem[0], 32'hBEEF0000);
    do_req("lh2",  1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 0, 0);
    do_req("lhu2", 1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 32'h0000BEEF, 1'b0, 2, 0, 0);

    do_req("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 0);
    check_val("sw10_waddr", last_waddr, 32'd4);
    check_val("sw10_mem", mem[4], 32'hDEADBEEF);
    do_req("lw10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 0);
    do_req("lwu10", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 0);

    do_req("lw4_stall", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h8899AABB, 1'b0, 5, 0, 3);

    do_req("lh5_mis", 1'b0, 2'b01, 1'b0, 32'h5, 32'h0,
           TRAP ? 32'h0 : 32'hFFFFAABB, TRAP, TRAP ? 1 : 2, 0, 0);
    do_req("lw6_mis", 1'b0, 2'b10, 1'b0, 32'h6, 32'h0,
           TRAP ? 32'h0 : 32'h8899AABB, TRAP, TRAP ? 1 : 2, 0, 0);
    do_req("lsz3", 1'b0, 2'b11, 1'b0, 32'h4, 32'h0,
           TRAP ? 32'h0 : 32'h8899AABB, TRAP, TRAP ? 1 : 2, 0, 0);
    do_req("sw_mis", 1'b1, 2'b10, 1'b0, 32'h13, 32'h12345678, 32'h0, TRAP, TRAP ? 1 : 2, TRAP ? 0 : 1, 0);
    check_val("sw_mis_mem", mem[4], TRAP ? 32'hDEADBEEF : 32'h12345678);

    // Reset while a sub-word store is in WR.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h9; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_write && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_val("rstwr_reached_wr", 32'(mem_write), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("rstwr_mem_write", 32'(mem_write), 32'd0);
    check_val("rstwr_resp_valid", 32'(resp_valid), 32'd0);
    check_val("rstwr_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_val("rstwr_no_resp", 32'(resp_valid), 32'd0);
    end
    check_val("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
